fir_coeff_ctrl: RTL and testbench

- Sequencer placed between the sample source and FIR_Filter.
- Forwards the sample stream (DIN/VIN) to the filter and owns the packed coefficient bus B.
- Reloads coefficients at run time: stalls the stream, drains the filter pipeline, serially loads NTAPS words into a shadow bank, then commits them to B atomically, so no output sample mixes old and new coefficients.

---
 rtl/fir_coeff_ctrl.sv | 159 +++++++++++++++
 tb/tb_fir_coeff_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_coeff_ctrl
// Brief    : Sample forwarder and atomic run-time coefficient reloader for
//            FIR_Filter (drain, serial shadow load, single-cycle commit).
// Revision : 1.0 - initial release
// ============================================================================
module fir_coeff_ctrl #(
    parameter int NB    = 9,
    parameter int NTAPS = 9,
    parameter int LAT   = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                SRC_VIN,
    input  logic [NB-1:0]       SRC_DIN,
    output logic                SRC_READY,
    output logic                VIN,
    output logic [NB-1:0]       DIN,
    output logic [NB*NTAPS-1:0] B,
    input  logic                CFG_START,
    input  logic                CFG_ABORT,
    input  logic                CFG_VALID,
    input  logic [NB-1:0]       CFG_DATA,
    output logic                CFG_READY,
    output logic                CFG_DONE,
    output logic                BUSY,
    output logic [7:0]          DROP_CNT
);

    localparam int C_IDX_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int C_CNT_W = $clog2(LAT + 2);
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(NTAPS - 1);
    localparam logic [C_CNT_W-1:0] C_LAT      = C_CNT_W'(LAT);
    localparam logic [C_CNT_W-1:0] C_ONE      = C_CNT_W'(1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_LOAD   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [C_CNT_W-1:0]   r_drain_cnt;
    logic [C_IDX_W-1:0]   r_idx;
    logic [NB-1:0]        r_shadow [NTAPS];
    logic                 r_vin;
    logic [NB-1:0]        r_din;
    logic [NB*NTAPS-1:0]  r_b;
    logic                 r_done;
    logic [7:0]           r_drop;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_abort;

    // Abort has priority over a coincident coefficient word.
    assign w_abort  = CFG_ABORT && ((r_state == S_DRAIN) || (r_state == S_LOAD));
    assign w_accept = (r_state == S_LOAD) && CFG_VALID && !CFG_ABORT;
    assign w_last   = w_accept && (r_idx == C_LAST_IDX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN: begin
                if (CFG_START) begin
                    w_next = (LAT == 0) ? S_LOAD : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (CFG_ABORT) begin
                    w_next = S_RUN;
                end else if (r_drain_cnt <= C_ONE) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (CFG_ABORT) begin
                    w_next = S_RUN;
                end else if (w_last) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: w_next = S_RUN;
            default:  w_next = S_RUN;
        endcase
    end

    // Counts remaining drain cycles so in-flight filter samples finish on old B.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_drain_cnt <= '0;
        end else if ((r_state == S_RUN) && CFG_START) begin
            r_drain_cnt <= C_LAT;
        end else if ((r_state == S_DRAIN) && (r_drain_cnt != '0)) begin
            r_drain_cnt <= r_drain_cnt - C_ONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vin  <= 1'b0;
            r_din  <= '0;
            r_done <= 1'b0;
            r_drop <= '0;
        end else begin
            r_vin  <= (r_state == S_RUN) && SRC_VIN;
            r_done <= w_last;
            if ((r_state == S_RUN) && SRC_VIN) begin
                r_din <= SRC_DIN;
            end
            if ((r_state != S_RUN) && SRC_VIN && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_idx <= '0;
            r_b   <= '0;
            for (int k = 0; k < NTAPS; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_shadow[r_idx] <= CFG_DATA;
                r_idx           <= w_last ? '0 : r_idx + 1'b1;
            end else if (w_abort) begin
                r_idx <= '0;
            end
            if (r_state == S_COMMIT) begin
                for (int k = 0; k < NTAPS; k++) begin
                    r_b[k*NB +: NB] <= r_shadow[k];
                end
            end
        end
    end

    assign SRC_READY = (r_state == S_RUN);
    assign CFG_READY = (r_state == S_LOAD);
    assign BUSY      = (r_state != S_RUN);
    assign VIN       = r_vin;
    assign DIN       = r_din;
    assign B         = r_b;
    assign CFG_DONE  = r_done;
    assign DROP_CNT  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_coeff_ctrl
// Brief    : Directed self-checking bench for fir_coeff_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_coeff_ctrl;

    localparam int NB    = 9;
    localparam int NTAPS = 9;
    localparam int LAT   = 2;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic                SRC_VIN = 1'b0;
    logic [NB-1:0]       SRC_DIN = '0;
    logic                SRC_READY;
    logic                VIN;
    logic [NB-1:0]       DIN;
    logic [NB*NTAPS-1:0] B;
    logic                CFG_START = 1'b0;
    logic                CFG_ABORT = 1'b0;
    logic                CFG_VALID = 1'b0;
    logic [NB-1:0]       CFG_DATA = '0;
    logic                CFG_READY;
    logic                CFG_DONE;
    logic                BUSY;
    logic [7:0]          DROP_CNT;

    int n_err    = 0;
    int n_chk    = 0;
    int done_cnt = 0;
    logic [NB-1:0]       exp_q [$];
    logic [NB*NTAPS-1:0] exp_b  = '0;
    logic [NB*NTAPS-1:0] prev_b = '0;

    fir_coeff_ctrl #(.NB(NB), .NTAPS(NTAPS), .LAT(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .SRC_VIN(SRC_VIN), .SRC_DIN(SRC_DIN), .SRC_READY(SRC_READY),
        .VIN(VIN), .DIN(DIN), .B(B),
        .CFG_START(CFG_START), .CFG_ABORT(CFG_ABORT), .CFG_VALID(CFG_VALID),
        .CFG_DATA(CFG_DATA), .CFG_READY(CFG_READY), .CFG_DONE(CFG_DONE),
        .BUSY(BUSY), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [NB-1:0] d);
        SRC_VIN = 1'b1;
        SRC_DIN = d;
        exp_q.push_back(d);
        tick();
    endtask

    // Start a reload and step until LOAD is reached (LAT drain cycles).
    task automatic enter_load();
        CFG_START = 1'b1;
        tick();
        CFG_START = 1'b0;
        repeat (LAT) tick();
    endtask

    task automatic reload(input logic [NB-1:0] base);
        enter_load();
        for (int k = 0; k < NTAPS; k++) begin
            CFG_VALID = 1'b1;
            CFG_DATA  = base + NB'(k);
            exp_b[k*NB +: NB] = base + NB'(k);
            tick();
        end
        CFG_VALID = 1'b0;
        tick();
    endtask

    // Scoreboard: every forwarded sample must match the oldest expected one.
    always @(negedge CLK) begin
        if (!RST) begin
            if (VIN === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("vin_unexpected", 128'(VIN), 128'(0));
                end else begin
                    chk("din_fwd", 128'(DIN), 128'(exp_q.pop_front()));
                end
            end
            if (CFG_DONE === 1'b1) done_cnt++;
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_vin",       128'(VIN),       128'(0));
        chk("rst_din",       128'(DIN),       128'(0));
        chk("rst_b",         128'(B),         128'(0));
        chk("rst_done",      128'(CFG_DONE),  128'(0));
        chk("rst_drop",      128'(DROP_CNT),  128'(0));
        chk("rst_src_ready", 128'(SRC_READY), 128'(1));
        chk("rst_cfg_ready", 128'(CFG_READY), 128'(0));
        chk("rst_busy",      128'(BUSY),      128'(0));
        RST = 1'b0;
        tick();

        for (int i = 1; i <= 5; i++) send(NB'(i));
        SRC_VIN = 1'b0;
        SRC_DIN = 9'h033;
        tick();
        chk("din_hold",    128'(DIN),      128'(5));
        chk("vin_idle",    128'(VIN),      128'(0));
        chk("stream_b",    128'(B),        128'(0));
        chk("stream_busy", 128'(BUSY),     128'(0));
        chk("stream_drop", 128'(DROP_CNT), 128'(0));

        // Reload with a sample in the START cycle and SRC_VIN held throughout.
        SRC_VIN   = 1'b1;
        SRC_DIN   = 9'h0AA;
        CFG_START = 1'b1;
        exp_q.push_back(9'h0AA);
        tick();
        chk("start_vin",  128'(VIN),      128'(1));
        chk("start_din",  128'(DIN),      128'(9'h0AA));
        chk("start_drop", 128'(DROP_CNT), 128'(0));
        chk("start_busy", 128'(BUSY),     128'(1));
        CFG_START = 1'b0;
        SRC_DIN   = 9'h0BB;
        CFG_VALID = 1'b1;
        CFG_DATA  = 9'h155;
        tick();
        chk("drain_cfg_ready", 128'(CFG_READY), 128'(0));
        CFG_VALID = 1'b0;
        tick();
        chk("load_cfg_ready", 128'(CFG_READY), 128'(1));
        for (int k = 0; k < NTAPS; k++) begin
            CFG_VALID = 1'b1;
            CFG_DATA  = NB'(k + 1);
            exp_b[k*NB +: NB] = NB'(k + 1);
            tick();
            if (k == 2) begin
                CFG_VALID = 1'b0;
                tick();
            end
        end
        CFG_VALID = 1'b0;
        chk("commit_done",  128'(CFG_DONE), 128'(1));
        chk("commit_b_old", 128'(B),        128'(0));
        tick();
        SRC_VIN = 1'b0;
        chk("done_pulse", 128'(CFG_DONE), 128'(0));
        chk("b_new",      128'(B),        128'(exp_b));
        chk("b_lsw",      128'(B[8:0]),   128'(1));
        chk("b_msw",      128'(B[80:72]), 128'(9));
        chk("run_busy",   128'(BUSY),     128'(0));
        chk("drop13",     128'(DROP_CNT), 128'(13));
        chk("done_cnt1",  128'(done_cnt), 128'(1));
        send(9'h042);
        SRC_VIN = 1'b0;
        tick();

        // Abort coinciding with a would-be word.
        prev_b = exp_b;
        enter_load();
        chk("abort_load", 128'(CFG_READY), 128'(1));
        for (int k = 0; k < 5; k++) begin
            CFG_VALID = 1'b1;
            CFG_DATA  = 9'h1FF;
            tick();
        end
        CFG_ABORT = 1'b1;
        tick();
        CFG_ABORT = 1'b0;
        CFG_VALID = 1'b0;
        chk("abort_busy",      128'(BUSY),      128'(0));
        chk("abort_src_ready", 128'(SRC_READY), 128'(1));
        tick();
        chk("abort_b_kept", 128'(B),        128'(prev_b));
        chk("abort_nodone", 128'(done_cnt), 128'(1));
        reload(9'h010);
        chk("reload_b",    128'(B),        128'(exp_b));
        chk("reload_b0",   128'(B[8:0]),   128'(9'h010));
        chk("done_cnt2",   128'(done_cnt), 128'(2));

        // Saturate the drop counter while parked in LOAD.
        enter_load();
        SRC_VIN = 1'b1;
        repeat (300) tick();
        chk("drop_sat", 128'(DROP_CNT), 128'(255));
        CFG_ABORT = 1'b1;
        tick();
        CFG_ABORT = 1'b0;
        SRC_VIN   = 1'b0;
        chk("drop_sat_hold", 128'(DROP_CNT), 128'(255));
        chk("sat_busy",      128'(BUSY),     128'(0));
        chk("sat_b_kept",    128'(B),        128'(exp_b));

        // Asynchronous reset in the middle of LOAD.
        enter_load();
        for (int k = 0; k < 4; k++) begin
            CFG_VALID = 1'b1;
            CFG_DATA  = 9'h0C3;
            tick();
        end
        CFG_VALID = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("arst_b",         128'(B),         128'(0));
        chk("arst_cfg_ready", 128'(CFG_READY), 128'(0));
        chk("arst_src_ready", 128'(SRC_READY), 128'(1));
        chk("arst_drop",      128'(DROP_CNT),  128'(0));
        tick();
        RST = 1'b0;
        tick();
        send(9'h123);
        SRC_VIN = 1'b0;
        tick();
        tick();
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
